aes256_axi_sequencer: RTL and testbench

- Control and sequencing block between the AXI-Lite slave register file and the AES256 device.
- Packs 32-bit register writes into 128-bit seed and data blocks.
- Sequences key load before data processing, drives the device start/done handshake with a timeout, and holds the result for word-wise readback.
- Replaces level/sensitivity-driven FIFO write strobes with explicit write-pulse decoding.

---
 rtl/aes256_axi_sequencer.sv | 145 ++++++++++++++
 tb/tb_aes256_axi_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_axi_sequencer.sv
// Sequencer between the AXI-Lite register file and the AES256 core: packs 32-bit
// writes into seed/data blocks, runs key load before data, and holds the result.
module aes256_axi_sequencer #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic         S_AXI_ACLK,
  input  logic         S_AXI_ARESETN,
  input  logic         wr_en,
  input  logic [1:0]   wr_addr,
  input  logic [31:0]  wr_data,
  output logic [127:0] dev_data,
  output logic [127:0] dev_seed,
  output logic [1:0]   dev_mode,
  output logic         dev_start,
  input  logic         dev_done,
  input  logic [127:0] dev_result,
  input  logic [1:0]   res_word_sel,
  output logic [31:0]  res_word,
  output logic [7:0]   status,
  output logic         irq
);

  typedef enum logic [1:0] {IDLE, WAIT_KEY, WAIT_DATA} state_t;

  // All state lives in one struct so reset and soft clear are a single '0 load.
  typedef struct packed {
    state_t             st;
    logic [127:0]       dbuf;
    logic [127:0]       sbuf;
    logic [127:0]       res;
    logic [1:0]         d_cnt;
    logic [1:0]         s_cnt;
    logic [1:0]         mode;
    logic [1:0]         dmode;
    logic               start;
    logic               dpend;
    logic               spend;
    logic               kval;
    logic               rval;
    logic               ovf;
    logic               tmo;
    logic               cfg;
    logic [CNT_W-1:0]   wcnt;
  } regs_t;

  regs_t r;

  logic soft_clr, term;
  assign soft_clr = wr_en && (wr_addr == 2'd0) && wr_data[0];
  assign term     = (r.wcnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r <= '0;
    end else if (soft_clr) begin
      r <= '0;
    end else begin
      r.start <= 1'b0;
      if (wr_en) begin
        case (wr_addr)
          2'd0: if (wr_data[1]) r.rval <= 1'b0;
          2'd1: if (wr_data[1]) r.cfg <= 1'b1;
                else            r.mode <= wr_data[1:0];
          // Drops test the registered pend flag, which also freezes the buffer.
          2'd2: if (r.dpend) r.ovf <= 1'b1;
                else begin
                  for (int i = 0; i < 4; i++)
                    if (r.d_cnt == 2'(i)) r.dbuf[127-32*i -: 32] <= wr_data;
                  r.d_cnt <= r.d_cnt + 2'd1;
                  if (r.d_cnt == 2'd3) r.dpend <= 1'b1;
                end
          default: if (r.spend) r.ovf <= 1'b1;
                else begin
                  for (int i = 0; i < 4; i++)
                    if (r.s_cnt == 2'(i)) r.sbuf[127-32*i -: 32] <= wr_data;
                  r.s_cnt <= r.s_cnt + 2'd1;
                  if (r.s_cnt == 2'd3) r.spend <= 1'b1;
                end
        endcase
      end
      // FSM follows the write decode so a same-cycle dev_done beats res_ack.
      case (r.st)
        IDLE: begin
          if (r.spend) begin
            r.dmode <= 2'd2;
            r.start <= 1'b1;
            r.wcnt  <= '0;
            r.st    <= WAIT_KEY;
          end else if (r.dpend && r.kval && !r.rval) begin
            r.dmode <= r.mode;
            r.start <= 1'b1;
            r.wcnt  <= '0;
            r.st    <= WAIT_DATA;
          end
        end
        WAIT_KEY: begin
          r.wcnt <= r.wcnt + CNT_W'(1);
          if (dev_done) begin
            r.kval  <= 1'b1;
            r.spend <= 1'b0;
            r.st    <= IDLE;
          end else if (term) begin
            r.tmo   <= 1'b1;
            r.kval  <= 1'b0;
            r.spend <= 1'b0;
            r.st    <= IDLE;
          end
        end
        WAIT_DATA: begin
          r.wcnt <= r.wcnt + CNT_W'(1);
          if (dev_done) begin
            r.res   <= dev_result;
            r.rval  <= 1'b1;
            r.dpend <= 1'b0;
            r.st    <= IDLE;
          end else if (term) begin
            r.tmo   <= 1'b1;
            r.dpend <= 1'b0;
            r.st    <= IDLE;
          end
        end
        default: r.st <= IDLE;
      endcase
    end
  end

  assign dev_data  = r.dbuf;
  assign dev_seed  = r.sbuf;
  assign dev_mode  = r.dmode;
  assign dev_start = r.start;
  assign status    = {r.cfg, r.tmo, r.ovf, r.rval, r.spend, r.dpend, r.kval, (r.st != IDLE)};
  assign irq       = r.rval | r.tmo | r.ovf;

  always_comb begin
    res_word = r.res[127:96];
    case (res_word_sel)
      2'd1:    res_word = r.res[95:64];
      2'd2:    res_word = r.res[63:32];
      2'd3:    res_word = r.res[31:0];
      default: res_word = r.res[127:96];
    endcase
  end

endmodule

// File: tb/tb_aes256_axi_sequencer.sv
// Bench for aes256_axi_sequencer: directed scenarios plus random traffic, all outputs
// compared every cycle against a word-queue / countdown model of the sequencer.
module tb_aes256_axi_sequencer;
  localparam int TO = 64;

  logic         clk, rst_n;
  logic         wr_en;
  logic [1:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [127:0] dev_data, dev_seed, dev_result;
  logic [1:0]   dev_mode, res_word_sel;
  logic         dev_start, dev_done, irq;
  logic [31:0]  res_word;
  logic [7:0]   status;

  aes256_axi_sequencer #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dev_data(dev_data), .dev_seed(dev_seed), .dev_mode(dev_mode), .dev_start(dev_start),
    .dev_done(dev_done), .dev_result(dev_result),
    .res_word_sel(res_word_sel), .res_word(res_word),
    .status(status), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]  m_dw [4];
  logic [31:0]  m_sw [4];
  int           m_dn, m_sn, m_phase, m_left;   // phase: 0 idle, 1 key load, 2 data
  bit           m_dp, m_sp, m_kv, m_rv, m_ovf, m_to, m_cfg, m_start;
  logic [1:0]   m_mode, m_dmode;
  logic [127:0] m_res;

  function automatic logic [127:0] cat4(input logic [31:0] w [4]);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 4; i++) begin m_dw[i] = '0; m_sw[i] = '0; end
    m_dn = 0; m_sn = 0; m_phase = 0; m_left = 0;
    m_dp = 0; m_sp = 0; m_kv = 0; m_rv = 0; m_ovf = 0; m_to = 0; m_cfg = 0; m_start = 0;
    m_mode = '0; m_dmode = '0; m_res = '0;
  endtask

  task automatic m_step();
    bit o_dp, o_sp, o_kv, o_rv;
    logic [1:0] o_mode;
    o_dp = m_dp; o_sp = m_sp; o_kv = m_kv; o_rv = m_rv; o_mode = m_mode;
    if (wr_en && wr_addr == 2'd0 && wr_data[0]) begin m_clear(); return; end
    m_start = 0;
    if (wr_en) begin
      if (wr_addr == 2'd0 && wr_data[1]) m_rv = 0;
      if (wr_addr == 2'd1) begin
        if (wr_data[1]) m_cfg = 1; else m_mode = wr_data[1:0];
      end
      if (wr_addr == 2'd2) begin
        if (o_dp) m_ovf = 1;
        else begin
          m_dw[m_dn] = wr_data; m_dn++;
          if (m_dn == 4) begin m_dn = 0; m_dp = 1; end
        end
      end
      if (wr_addr == 2'd3) begin
        if (o_sp) m_ovf = 1;
        else begin
          m_sw[m_sn] = wr_data; m_sn++;
          if (m_sn == 4) begin m_sn = 0; m_sp = 1; end
        end
      end
    end
    if (m_phase == 0) begin
      if (o_sp) begin
        m_start = 1; m_dmode = 2'd2; m_phase = 1; m_left = TO;
      end else if (o_dp && o_kv && !o_rv) begin
        m_start = 1; m_dmode = o_mode; m_phase = 2; m_left = TO;
      end
    end else begin
      m_left--;
      if (dev_done) begin
        if (m_phase == 1) begin m_kv = 1; m_sp = 0; end
        else begin m_res = dev_result; m_rv = 1; m_dp = 0; end
        m_phase = 0;
      end else if (m_left == 0) begin
        m_to = 1;
        if (m_phase == 1) begin m_kv = 0; m_sp = 0; end
        else m_dp = 0;
        m_phase = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) m_clear();
    else m_step();
  end

  // Single compare process: every output, every cycle.
  always @(negedge clk) begin
    logic [127:0] sh;
    if (!rst_n) begin
      chk("rst_status", 128'(status), '0);
      chk("rst_start", 128'(dev_start), '0);
      chk("rst_irq", 128'(irq), '0);
      chk("rst_dev_data", dev_data, '0);
      chk("rst_res_word", 128'(res_word), '0);
    end else begin
      sh = m_res >> (96 - 32 * res_word_sel);
      chk("dev_data", dev_data, cat4(m_dw));
      chk("dev_seed", dev_seed, cat4(m_sw));
      chk("dev_mode", 128'(dev_mode), 128'(m_dmode));
      chk("dev_start", 128'(dev_start), 128'(m_start));
      chk("status", 128'(status),
          128'({m_cfg, m_to, m_ovf, m_rv, m_sp, m_dp, m_kv, (m_phase != 0)}));
      chk("irq", 128'(irq), 128'(m_rv | m_to | m_ovf));
      chk("res_word", 128'(res_word), 128'(sh[31:0]));
    end
  end

  // ---------------- device model ----------------
  int           lat_cfg = 5, dcnt = 0;   // lat 0: never completes
  bit           rand_lat = 0;
  logic [127:0] res_pat = {4{32'hA5A5A5A5}};

  always @(negedge clk) begin
    int r;
    dev_done = 1'b0;
    if (dev_start) begin
      if (rand_lat) begin
        r = int'($urandom_range(0, 9));
        dcnt = (r < 7) ? int'($urandom_range(1, 7)) : (r == 7) ? 63 : (r == 8) ? 64 : 0;
      end else dcnt = lat_cfg;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        dev_done = 1'b1;
        dev_result = rand_lat ? {$urandom(), $urandom(), $urandom(), $urandom()} : res_pat;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr_block(input logic [1:0] a, input logic [31:0] base, input logic [31:0] step);
    for (int i = 0; i < 4; i++) wr(a, base + step * i);
  endtask

  task automatic wait_start(output int c, output logic [1:0] md);
    int n = 0;
    do begin tick(); n++; end while (!dev_start && n < 300);
    checks++;
    if (!dev_start) begin
      errors++;
      $display("FAIL wait_start: got no dev_start, expected one within 300 cycles");
    end
    c = cyc; md = dev_mode;
  endtask

  task automatic wait_stat(input int b, output int c);
    int n = 0;
    while (!status[b] && n < 300) begin tick(); n++; end
    checks++;
    if (!status[b]) begin
      errors++;
      $display("FAIL wait_status_bit%0d: got 0, expected 1 within 300 cycles", b);
    end
    c = cyc;
  endtask

  initial begin
    int s, k, t, cnt;
    logic [1:0] md;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; res_word_sel = '0;
    dev_done = 1'b0; dev_result = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset_status", 128'(status), '0);

    // Key load then data
    wr_block(2'd3, 32'h00010203, 32'h04040404);
    wait_start(s, md);
    chk("t1_key_mode", 128'(md), 128'd2);
    chk("t1_seed", dev_seed, 128'h00010203_04050607_08090A0B_0C0D0E0F);
    wr(2'd1, 32'd0);
    wr_block(2'd2, 32'h10111213, 32'h04040404);
    wait_start(s, md);
    chk("t1_data_mode", 128'(md), 128'd0);
    wait_stat(4, k);
    chk("t1_irq", 128'(irq), 128'd1);
    for (int i = 0; i < 4; i++) begin
      res_word_sel = 2'(i);
      tick();
      chk("t1_res_word", 128'(res_word), 128'h A5A5A5A5);
    end

    // Data before key
    wr(2'd0, 32'd1);
    wr_block(2'd2, 32'hD0000000, 32'd1);
    cnt = 0;
    repeat (10) begin tick(); if (dev_start) cnt++; end
    chk("t2_no_start", 128'(cnt), '0);
    chk("t2_data_pend", 128'(status[2]), 128'd1);
    wr_block(2'd3, 32'h5EED0000, 32'd1);
    wait_start(s, md);
    chk("t2_key_mode", 128'(md), 128'd2);
    wait_stat(1, k);
    wait_start(t, md);
    chk("t2_data_mode", 128'(md), 128'd0);
    chk("t2_gap", 128'(t - k >= 1), 128'd1);

    // Overflow while a block is held behind res_valid
    wait_stat(4, k);
    wr_block(2'd2, 32'hE0000000, 32'd1);
    chk("t3_block", dev_data, 128'hE0000000_E0000001_E0000002_E0000003);
    wr(2'd2, 32'hBAD0BAD0);
    chk("t3_ovf", 128'(status[5]), 128'd1);
    chk("t3_block_kept", dev_data, 128'hE0000000_E0000001_E0000002_E0000003);
    wr(2'd0, 32'd2);
    wait_start(s, md);
    chk("t3_block_run", dev_data, 128'hE0000000_E0000001_E0000002_E0000003);

    // Timeout on key load
    wr(2'd0, 32'd1);
    lat_cfg = 0;
    wr_block(2'd3, 32'h11110000, 32'd1);
    wait_start(s, md);
    wait_stat(6, t);
    chk("t4_timeout_cycles", 128'(t - s), 128'd64);
    chk("t4_busy", 128'(status[0]), '0);
    chk("t4_key_valid", 128'(status[1]), '0);

    // done on the terminal count; then res_ack coinciding with done
    wr(2'd0, 32'd1);
    lat_cfg = 5;
    wr_block(2'd3, 32'h22220000, 32'd1);
    wait_stat(1, k);
    lat_cfg = 63;
    wr_block(2'd2, 32'h33330000, 32'd1);
    wait_stat(4, k);
    chk("t5_term_timeout", 128'(status[6]), '0);
    wr(2'd0, 32'd2);
    lat_cfg = 5;
    res_pat = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    res_word_sel = 2'd0;
    wr_block(2'd2, 32'h44440000, 32'd1);
    wait_start(s, md);
    repeat (5) tick();
    wr(2'd0, 32'd2);
    chk("t5_ack_done_rv", 128'(status[4]), 128'd1);
    chk("t5_ack_done_word", 128'(res_word), 128'h01234567);

    // soft_clr in WAIT_DATA, late done ignored
    wr(2'd0, 32'd1);
    lat_cfg = 5;
    wr_block(2'd3, 32'h55550000, 32'd1);
    wait_stat(1, k);
    lat_cfg = 20;
    wr(2'd1, 32'd1);
    wr_block(2'd2, 32'h66660000, 32'd1);
    wait_start(s, md);
    repeat (3) tick();
    wr(2'd0, 32'd1);
    cnt = 0;
    repeat (30) begin tick(); if (dev_start) cnt++; end
    chk("t6_no_start", 128'(cnt), '0);
    chk("t6_status", 128'(status), '0);

    // Reset mid-packing
    wr(2'd2, 32'hDEAD0000);
    wr(2'd2, 32'hDEAD0001);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t7_dev_data_rst", dev_data, '0);
    wr_block(2'd2, 32'hF0000000, 32'd1);
    chk("t7_block", dev_data, 128'hF0000000_F0000001_F0000002_F0000003);
    chk("t7_status", 128'(status), 128'h04);

    // Random traffic against the model
    res_pat = {4{32'hA5A5A5A5}};
    rand_lat = 1;
    wr(2'd0, 32'd1);
    for (int c = 0; c < 3000; c++) begin
      res_word_sel = 2'($urandom_range(0, 3));
      wr_en = ($urandom_range(0, 9) < 4);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = $urandom();
      if (wr_addr == 2'd0) begin
        wr_data[0] = ($urandom_range(0, 99) < 3);
        wr_data[1] = 1'($urandom_range(0, 1));
      end else if (wr_addr == 2'd1) begin
        wr_data[1] = ($urandom_range(0, 9) == 0);
      end
      tick();
    end
    wr_en = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
